ctrl_div: RTL

- Sequencing controller and iterative datapath for an unsigned restoring (shift-subtract) divider.
- Accepts an operand pair on a start pulse and runs one quotient bit per clock.
- Emits quotient and remainder with a one-cycle fim_div strobe. These three outputs connect directly to the quoc/rest/fim_div inputs of the downstream result register.
- Owns the start/busy handshake and divide-by-zero handling.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_passo.sv | 27 ++
 rtl/ctrl_div.sv | 99 +++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: the controller state type, the
// default width, the divide-by-zero quotient and a helper for the step counter width.
package div_pkg;

   localparam int DIV_N = 8;

   // Wider than any practical N; the user truncates it to its own width.
   localparam logic [63:0] QUOC_DIV0 = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/div_passo.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_passo
   import div_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic [N-1:0] i_r,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_d,
   output logic [N:0]   o_r_next,
   output logic [N-1:0] o_a_next
);

   logic [N:0] w_rs;
   logic [N:0] w_diff;
   logic       w_ge;

   // The partial remainder never exceeds N bits between steps, so the shift
   // needs one extra bit only for the compare and subtract.
   assign w_rs     = {i_r, i_a[N-1]};
   assign w_diff   = w_rs - {1'b0, i_d};
   assign w_ge     = (w_rs >= {1'b0, i_d});
   assign o_r_next = w_ge ? w_diff : w_rs;
   assign o_a_next = {i_a[N-2:0], w_ge};

endmodule

// File: rtl/ctrl_div.sv
// Sequencer for an iterative unsigned divider: one quotient bit per clock, start/busy
// handshake, divide-by-zero short-circuit and a one-cycle completion strobe.
//
//   state | meaning
//   IDLE  | waiting for start
//   CALC  | iterating, one quotient bit per edge
//   DONE  | result valid, fim_div high; start here is accepted back-to-back
module ctrl_div
   import div_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividendo,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] quoc,
   output logic [N:0]   rest,
   output logic         fim_div,
   output logic         busy,
   output logic         erro_div0
);

   localparam int CNT_W = cnt_w(N);

   state_t           r_state;
   logic [N-1:0]     r_a;
   logic [N-1:0]     r_d;
   logic [N-1:0]     r_r;
   logic [CNT_W-1:0] r_cnt;
   logic [N-1:0]     r_quoc;
   logic [N:0]       r_rest;
   logic             r_erro;

   logic [N:0]       w_r_next;
   logic [N-1:0]     w_a_next;

   div_passo #(.N(N)) u_passo (
      .i_r      (r_r),
      .i_a      (r_a),
      .i_d      (r_d),
      .o_r_next (w_r_next),
      .o_a_next (w_a_next)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_d     <= '0;
         r_r     <= '0;
         r_cnt   <= '0;
         r_quoc  <= '0;
         r_rest  <= '0;
         r_erro  <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  if (divisor != '0) begin
                     r_a     <= dividendo;
                     r_d     <= divisor;
                     r_r     <= '0;
                     r_cnt   <= '0;
                     r_erro  <= 1'b0;
                     r_state <= CALC;
                  end else begin
                     r_quoc  <= N'(QUOC_DIV0);
                     r_rest  <= {1'b0, dividendo};
                     r_erro  <= 1'b1;
                     r_state <= DONE;
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
            CALC: begin
               r_a   <= w_a_next;
               r_r   <= w_r_next[N-1:0];
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(N-1)) begin
                  r_quoc  <= w_a_next;
                  r_rest  <= w_r_next;
                  r_state <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign quoc      = r_quoc;
   assign rest      = r_rest;
   assign erro_div0 = r_erro;
   assign fim_div   = (r_state == DONE);
   assign busy      = (r_state == CALC);

endmodule
